// File: rtl/nubus_wbuf_pkg.sv
// Shared types for the NuBus posted-write buffer.
//   wbuf_entry_t : one queued write (word address, byte enables, data)
//   wbuf_state_t : upstream request FSM states
//   MEM_RD       : byte-enable code that marks a read on the mem_* protocol
// Optional feature macro used by the files that import this package:
//   NUBUS_WBUF_FWD_EN - forward full-word queued writes to matching reads.
package nubus_wbuf_pkg;

  localparam logic [3:0] MEM_RD = 4'h0;
  localparam logic [3:0] BE_ALL = 4'hF;

  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  write;
    logic [31:0] wdata;
  } wbuf_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WACK,
    ST_DRAIN,
    ST_RD,
    ST_RACK
  } wbuf_state_t;

endpackage

// File: rtl/nubus_wbuf_fifo.sv
// Circular write queue for the posted-write buffer.
// Ports:
//   clk, resetn      : clock, synchronous active-low reset (discards contents)
//   push, push_entry : enqueue one entry (caller guarantees not full)
//   pop              : dequeue the head (caller guarantees not empty)
//   head             : oldest entry
//   count/full/empty : occupancy, from registered state
//   entries          : (NUBUS_WBUF_FWD_EN only) all slots ordered by age,
//                      entries[0] = head; slots at index >= count are stale.
module nubus_wbuf_fifo
  import nubus_wbuf_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    push,
  input  wbuf_entry_t             push_entry,
  input  logic                    pop,
  output wbuf_entry_t             head,
  output logic [DEPTH_LOG2:0]     count,
  output logic                    full,
  output logic                    empty
`ifdef NUBUS_WBUF_FWD_EN
  ,
  output wbuf_entry_t [(1<<DEPTH_LOG2)-1:0] entries
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  wbuf_entry_t             mem_reg [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_reg;
  logic [DEPTH_LOG2-1:0]   rd_ptr_reg;
  logic [DEPTH_LOG2:0]     count_reg;

  // Pointers are DEPTH_LOG2 wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Payload storage carries no reset; validity lives in the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= push_entry;
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;
  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);

`ifdef NUBUS_WBUF_FWD_EN
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
    logic [DEPTH_LOG2-1:0] idx;
    assign idx         = rd_ptr_reg + DEPTH_LOG2'(gi);
    assign entries[gi] = mem_reg[idx];
  end
`endif

endmodule

// File: rtl/nubus_mem_wbuf.sv
// Posted-write buffer between the NuBus slave mem_* port and card memory.
// Writes are acknowledged once queued; reads wait until every queued write
// has reached memory, so ordering is preserved.
// Ports:
//   mem_clk, mem_resetn         : clock, synchronous active-low reset
//   s_valid/s_write/s_addr/s_wdata, s_ready/s_rdata : upstream slave side
//   m_valid/m_write/m_addr/m_wdata, m_ready/m_rdata : downstream memory side
//   wbuf_empty                  : queue empty and no write in flight
// Macro NUBUS_WBUF_FWD_EN: a read hitting a queued full-word write is
// answered from the queue without draining or touching memory.
module nubus_mem_wbuf
  import nubus_wbuf_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic        mem_clk,
  input  logic        mem_resetn,
  input  logic        s_valid,
  input  logic [3:0]  s_write,
  input  logic [31:0] s_addr,
  input  logic [31:0] s_wdata,
  output logic        s_ready,
  output logic [31:0] s_rdata,
  output logic        m_valid,
  output logic [3:0]  m_write,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic [31:0] m_rdata,
  output logic        wbuf_empty
);

  wbuf_state_t         state_reg, state_next;
  logic                m_valid_reg;
  logic [3:0]          m_write_reg;
  logic [31:0]         m_addr_reg, m_wdata_reg, rdata_reg;
  logic                push, pop, flight, drain_go, read_done, read_start;
  logic                fifo_full, fifo_empty;
  logic [DEPTH_LOG2:0] fifo_count;
  wbuf_entry_t         push_entry, head;
  logic                unused_bits;

  assign push_entry = '{addr: s_addr[31:2], write: s_write, wdata: s_wdata};

`ifdef NUBUS_WBUF_FWD_EN
  localparam int DEPTH = 1 << DEPTH_LOG2;
  wbuf_entry_t [DEPTH-1:0] entries;
  logic                    fwd_hit;
  logic [31:0]             fwd_data;

  // Scan oldest to youngest so the youngest address match wins; a partial
  // youngest match must not forward stale bytes, so it clears the hit.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k < int'(fifo_count) && entries[k].addr == s_addr[31:2]) begin
        fwd_hit  = (entries[k].write == BE_ALL);
        fwd_data = entries[k].wdata;
      end
    end
  end
  assign unused_bits = ^s_addr[1:0];
`else
  assign unused_bits = ^{s_addr[1:0], fifo_count};
`endif

  nubus_wbuf_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk        (mem_clk),
    .resetn     (mem_resetn),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
`ifdef NUBUS_WBUF_FWD_EN
    ,
    .entries    (entries)
`endif
  );

  // Only drained writes carry non-zero byte enables on m_write.
  assign flight     = m_valid_reg && (m_write_reg != MEM_RD);
  assign pop        = flight && m_ready;
  assign wbuf_empty = fifo_empty && !flight;
  assign read_done  = (state_reg == ST_RD) && m_valid_reg && m_ready;
  assign drain_go   = !fifo_empty && (state_reg != ST_RD) && (state_reg != ST_RACK);
  assign read_start = (state_next == ST_RD) && (state_reg != ST_RD);

  always_comb begin
    state_next = state_reg;
    push       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (s_valid) begin
          if (s_write != MEM_RD) begin
            // Full is judged on the registered count: no push-through-pop.
            if (!fifo_full) begin
              push       = 1'b1;
              state_next = ST_WACK;
            end
          end
`ifdef NUBUS_WBUF_FWD_EN
          else if (fwd_hit) state_next = ST_RACK;
`endif
          else if (!wbuf_empty) state_next = ST_DRAIN;
          else                  state_next = ST_RD;
        end
      end
      ST_WACK:  state_next = ST_IDLE;
      ST_DRAIN: if (wbuf_empty) state_next = ST_RD;
      ST_RD:    if (read_done) state_next = ST_RACK;
      ST_RACK:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // One downstream request register shared by drain writes and reads. A
  // completed transfer always drops m_valid for a cycle before the next.
  always_ff @(posedge mem_clk) begin
    if (!mem_resetn) begin
      state_reg   <= ST_IDLE;
      m_valid_reg <= 1'b0;
      m_write_reg <= '0;
      m_addr_reg  <= '0;
      m_wdata_reg <= '0;
      rdata_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (m_valid_reg) begin
        if (m_ready) m_valid_reg <= 1'b0;
      end else if (read_start) begin
        m_valid_reg <= 1'b1;
        m_write_reg <= MEM_RD;
        m_addr_reg  <= {s_addr[31:2], 2'b00};
      end else if (drain_go) begin
        m_valid_reg <= 1'b1;
        m_write_reg <= head.write;
        m_addr_reg  <= {head.addr, 2'b00};
        m_wdata_reg <= head.wdata;
      end
      if (read_done) rdata_reg <= m_rdata;
`ifdef NUBUS_WBUF_FWD_EN
      else if (state_reg == ST_IDLE && state_next == ST_RACK) rdata_reg <= fwd_data;
`endif
    end
  end

  assign s_ready = (state_reg == ST_WACK) || (state_reg == ST_RACK);
  assign s_rdata = rdata_reg;
  assign m_valid = m_valid_reg;
  assign m_write = m_write_reg;
  assign m_addr  = m_addr_reg;
  assign m_wdata = m_wdata_reg;

endmodule

// File: tb/tb_nubus_mem_wbuf.sv
// Self-checking bench for nubus_mem_wbuf with a behavioural wait-state memory.
// Honours NUBUS_WBUF_FWD_EN for the forwarding scenario.
module tb_nubus_mem_wbuf;

  logic        clk, mem_resetn;
  logic        s_valid, s_ready;
  logic [3:0]  s_write;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        m_valid, m_ready, wbuf_empty;
  logic [3:0]  m_write;
  logic [31:0] m_addr, m_wdata, m_rdata;

  nubus_mem_wbuf dut (
    .mem_clk(clk), .mem_resetn(mem_resetn),
    .s_valid(s_valid), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .m_valid(m_valid), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .wbuf_empty(wbuf_empty)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] data; } wb_t;
  typedef struct { logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; logic [31:0] exp; } vec_t;

  wb_t         exp_wr[$];
  logic [31:0] mem_a [logic [29:0]];
  int tests = 0, fails = 0;
  int mem_wait = 0, wcnt = 0, wr_done = 0, rd_cnt = 0, rd_ready_cyc = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %08h expected %08h", nm, act, exp);
    end else
      $display("[TB] ok   %s: %08h", nm, act);
  endtask

  // Memory: m_ready after mem_wait cycles of m_valid; checks drained writes
  // against the scoreboard and that no read overtakes a pending write.
  initial begin
    logic [31:0] cur;
    wb_t w;
    m_ready = 0;
    m_rdata = 0;
    forever begin
      @(posedge clk); #1;
      if (m_ready) m_ready = 0;
      else if (m_valid) begin
        if (wcnt < mem_wait) wcnt++;
        else begin
          wcnt = 0;
          m_ready = 1;
          cur = mem_a.exists(m_addr[31:2]) ? mem_a[m_addr[31:2]] : 32'h0;
          if (m_write == 4'h0) begin
            m_rdata = cur;
            rd_cnt++;
            rd_ready_cyc = cyc;
            chk("mem read: pending writes", 32'(exp_wr.size()), 32'd0);
          end else begin
            if (exp_wr.size() == 0) begin
              tests++;
              fails++;
              $display("[TB] FAIL unexpected mem write: got addr %08h expected none", m_addr);
            end else begin
              w = exp_wr.pop_front();
              chk("mem write addr", m_addr, w.addr);
              chk("mem write be", 32'(m_write), 32'(w.be));
              chk("mem write data", m_wdata, w.data);
            end
            for (int b = 0; b < 4; b++)
              if (m_write[b]) cur[8*b +: 8] = m_wdata[8*b +: 8];
            mem_a[m_addr[31:2]] = cur;
            wr_done++;
          end
        end
      end else wcnt = 0;
    end
  end

  task automatic do_op(input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output int lat, output int sr_cyc);
    wb_t w;
    if (be != 4'h0) begin
      w.addr = {addr[31:2], 2'b00};
      w.be   = be;
      w.data = wdata;
      exp_wr.push_back(w);
    end
    s_write = be; s_addr = addr; s_wdata = wdata; s_valid = 1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!s_ready && lat < 400);
    if (!s_ready) chk("s_ready timeout", 32'(s_ready), 32'd1);
    rdata  = s_rdata;
    sr_cyc = cyc;
    s_valid = 0; s_write = 0;
    @(posedge clk); #1;
  endtask

  task automatic wait_empty(input string nm);
    int n = 0;
    while (!wbuf_empty && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, 32'(wbuf_empty), 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[14];
    logic [31:0] rd;
    int lat, src, wd0, rc0, n;

    tbl[0]  = '{4'hF, 32'hF000_0000, 32'h8765_4321, 32'h0};
    tbl[1]  = '{4'h0, 32'hF000_0000, 32'h0,         32'h8765_4321};
    tbl[2]  = '{4'h3, 32'hF000_0004, 32'h8765_4321, 32'h0};
    tbl[3]  = '{4'h0, 32'hF000_0004, 32'h0,         32'h0000_4321};
    tbl[4]  = '{4'hC, 32'hF000_0004, 32'hAABB_CCDD, 32'h0};
    tbl[5]  = '{4'h0, 32'hF000_0004, 32'h0,         32'hAABB_4321};
    tbl[6]  = '{4'h1, 32'hF000_0008, 32'h0000_00EE, 32'h0};
    tbl[7]  = '{4'h6, 32'hF000_0008, 32'h1234_5678, 32'h0};
    tbl[8]  = '{4'h0, 32'hF000_0008, 32'h0,         32'h0034_56EE};
    tbl[9]  = '{4'hF, 32'hF000_0020, 32'h1111_2222, 32'h0};
    tbl[10] = '{4'hF, 32'hF000_0024, 32'h3333_4444, 32'h0};
    tbl[11] = '{4'h0, 32'hF000_0023, 32'h0,         32'h1111_2222};
    tbl[12] = '{4'h8, 32'hF000_000C, 32'h9A00_0000, 32'h0};
    tbl[13] = '{4'h0, 32'hF000_000C, 32'h0,         32'h9A00_0000};

    s_valid = 0; s_write = 0; s_addr = 0; s_wdata = 0;
    mem_resetn = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset s_ready", 32'(s_ready), 32'd0);
    chk("reset s_rdata", s_rdata, 32'h0);
    chk("reset m_valid", 32'(m_valid), 32'd0);
    chk("reset m_write", 32'(m_write), 32'd0);
    chk("reset m_addr", m_addr, 32'h0);
    chk("reset m_wdata", m_wdata, 32'h0);
    chk("reset wbuf_empty", 32'(wbuf_empty), 32'd1);
    mem_resetn = 1;
    @(posedge clk); #1;

    // Posted write: ack one cycle after accept, memory written later.
    wd0 = wr_done;
    mem_wait = 1;
    do_op(4'hF, 32'hF000_0000, 32'h8765_4321, rd, lat, src);
    chk("t1 write latency", 32'(lat), 32'd1);
    chk("t1 still queued", 32'(wbuf_empty), 32'd0);
    wait_empty("t1 wbuf_empty returns");
    chk("t1 writes reached memory", 32'(wr_done - wd0), 32'd1);
    chk("t1 memory word", mem_a[30'h3C00_0000], 32'h8765_4321);

    for (int i = 0; i < 14; i++) begin
      mem_wait = i % 3;
      do_op(tbl[i].be, tbl[i].addr, tbl[i].wdata, rd, lat, src);
      if (tbl[i].be == 4'h0) chk($sformatf("vec%0d read data", i), rd, tbl[i].exp);
      else                   chk($sformatf("vec%0d write latency", i), 32'(lat), 32'd1);
    end
    wait_empty("table drained");

    // Read with empty queue: request next cycle, ack one cycle after m_ready.
    mem_wait = 2;
    s_write = 4'h0; s_addr = 32'hF000_0008; s_valid = 1;
    @(posedge clk); #1;
    chk("t4 m_valid next cycle", 32'(m_valid), 32'd1);
    chk("t4 m_write is read", 32'(m_write), 32'd0);
    chk("t4 m_addr", m_addr, 32'hF000_0008);
    s_valid = 0;
    do_op(4'h0, 32'hF000_0008, 32'h0, rd, lat, src);
    chk("t4 read data", rd, 32'h0034_56EE);
    chk("t4 s_ready after m_ready", 32'(src - rd_ready_cyc), 32'd1);

    // Fill the queue behind a slow memory; fifth write must stall.
    mem_wait = 8;
    for (int i = 0; i < 4; i++) begin
      do_op(4'hF, 32'hF000_0000 + 32'(4 * i), 32'h2000_0000 + 32'(i), rd, lat, src);
      chk($sformatf("t2 write%0d latency", i), 32'(lat), 32'd1);
    end
    wd0 = wr_done;
    do_op(4'hF, 32'hF000_0010, 32'h2000_0004, rd, lat, src);
    chk("t2 fifth write stalled", 32'(lat > 1), 32'd1);
    chk("t2 pop before fifth accept", 32'(wr_done - wd0 >= 1), 32'd1);
    wait_empty("t2 drained");

    // Reset while a drain write is in flight with a second entry queued.
    mem_wait = 50;
    do_op(4'hF, 32'hF000_0020, 32'h5555_0000, rd, lat, src);
    do_op(4'hF, 32'hF000_0024, 32'h6666_0000, rd, lat, src);
    n = 0;
    while (!m_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5 m_valid before reset", 32'(m_valid), 32'd1);
    mem_resetn = 0;
    @(posedge clk); #1;
    chk("t5 m_valid after reset", 32'(m_valid), 32'd0);
    chk("t5 wbuf_empty after reset", 32'(wbuf_empty), 32'd1);
    mem_resetn = 1;
    exp_wr.delete();
    mem_wait = 1;
    do_op(4'h0, 32'hF000_0020, 32'h0, rd, lat, src);
    chk("t5 read pre-reset word0", rd, 32'h1111_2222);
    do_op(4'h0, 32'hF000_0024, 32'h0, rd, lat, src);
    chk("t5 read pre-reset word1", rd, 32'h3333_4444);

    // Full-word write held off by memory, then read of the same word.
    mem_wait = 40;
    do_op(4'hF, 32'hF000_0010, 32'hDEAD_BEEF, rd, lat, src);
    rc0 = rd_cnt;
    do_op(4'h0, 32'hF000_0010, 32'h0, rd, lat, src);
    chk("t6 read data", rd, 32'hDEAD_BEEF);
`ifdef NUBUS_WBUF_FWD_EN
    chk("t6 forwarded latency", 32'(lat), 32'd1);
    chk("t6 no memory read", 32'(rd_cnt - rc0), 32'd0);
`else
    chk("t6 read waited for drain", 32'(lat > 40), 32'd1);
    chk("t6 one memory read", 32'(rd_cnt - rc0), 32'd1);
`endif
    mem_wait = 0;
    wait_empty("t6 drained");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
